// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM and ALU decoder for the multicycle MIPS datapath. Decodes the
//   instruction register's op/funct fields into datapath enables, mux selects
//   and the ALU f[2:0] control word, and resolves beq using the ALU zero flag.
//
// Parameters
//   EXT_IMM     1: andi/ori/slti execute on the immediate path; 0: illegal ops
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; returns the FSM to FETCH
//   op, funct   instr[31:26] / instr[5:0] from the instruction register
//   zero        ALU zero flag, used combinationally in BRANCH
//   alucontrol  ALU f: 010 add, 110 sub, 000 and, 001 or, 111 slt
//   alusrca     0=PC, 1=regA
//   alusrcb     00=regB, 01=4, 10=imm, 11=imm<<2
//   pcsrc       00=ALU result, 01=ALUOut, 10=jump target
//   iord        0=PC address, 1=ALUOut address
//   regdst      0=rt, 1=rd
//   memtoreg    0=ALUOut, 1=memory data
//   immzext     1=zero-extend immediate (andi/ori)
//   irwrite     instruction register load
//   memwrite    memory write strobe
//   regwrite    register file write
//   pcen        PC load: pcwrite | (branch & zero)
//   illegal_op  one-cycle pulse on an unsupported op or funct
//   state       current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit EXT_IMM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       immzext,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    state_t state_q, state_d;
    logic   pcwrite, branch;
    logic   ext_op;

    // Extended immediate ops are only decoded when the option is built in.
    assign ext_op = EXT_IMM && ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI));
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        alucontrol = 3'b010;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        immzext    = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm<<2) in case this is a branch.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_IMMEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        if (ext_op) begin
                            state_d = S_IMMEXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    FN_ADD: alucontrol = 3'b010;
                    FN_SUB: alucontrol = 3'b110;
                    FN_AND: alucontrol = 3'b000;
                    FN_OR:  alucontrol = 3'b001;
                    FN_SLT: alucontrol = 3'b111;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            S_IMMEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_IMMWB;
                case (op)
                    OP_ANDI: begin alucontrol = 3'b000; immzext = 1'b1; end
                    OP_ORI:  begin alucontrol = 3'b001; immzext = 1'b1; end
                    OP_SLTI: alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            S_IMMWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                // Unused encodings: everything quiet, recover to FETCH.
                alucontrol = 3'b000;
            end
        endcase

        pcen = pcwrite | (branch & zero);

        // Strobes stay silent while reset is asserted.
        if (reset) begin
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;

  typedef struct packed {
    logic [3:0] state;
    logic [2:0] alu;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcsrc;
    logic       iord, regdst, memtoreg, immzext, irwrite, memwrite, regwrite, pcen, illegal;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic br;
  } step_t;

  logic clk = 1'b0;
  logic reset, rst0, zero;
  logic [5:0] op, funct;
  int total = 0, bad = 0;
  step_t q[$];

  always #5 clk = ~clk;

  // DUT with the immediate extension
  logic [3:0] st1; logic [2:0] ac1; logic [1:0] asb1, pcs1;
  logic asa1, iord1, rd1, m2r1, zx1, irw1, mw1, rw1, pcen1, ill1;
  // DUT without it
  logic [3:0] st0; logic [2:0] ac0; logic [1:0] asb0, pcs0;
  logic asa0, iord0, rd0, m2r0, zx0, irw0, mw0, rw0, pcen0, ill0;
  obs_t obs1, obs0;

  multicycle_controller #(.EXT_IMM(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(ac1), .alusrca(asa1), .alusrcb(asb1), .pcsrc(pcs1), .iord(iord1),
    .regdst(rd1), .memtoreg(m2r1), .immzext(zx1), .irwrite(irw1), .memwrite(mw1),
    .regwrite(rw1), .pcen(pcen1), .illegal_op(ill1), .state(st1));

  multicycle_controller #(.EXT_IMM(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
    .alucontrol(ac0), .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0), .iord(iord0),
    .regdst(rd0), .memtoreg(m2r0), .immzext(zx0), .irwrite(irw0), .memwrite(mw0),
    .regwrite(rw0), .pcen(pcen0), .illegal_op(ill0), .state(st0));

  assign obs1 = {st1, ac1, asa1, asb1, pcs1, iord1, rd1, m2r1, zx1, irw1, mw1, rw1, pcen1, ill1};
  assign obs0 = {st0, ac0, asa0, asb0, pcs0, iord0, rd0, m2r0, zx0, irw0, mw0, rw0, pcen0, ill0};

  function automatic step_t mk(input int s);
    step_t t;
    t = '0;
    t.o.state = s[3:0];
    t.o.alu = 3'b010;
    return t;
  endfunction

  // Reference: the full per-cycle control trace of one instruction, FETCH onward.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input bit ext);
    step_t t;
    bit legal;
    q.delete();
    t = mk(0); t.o.asb = 2'b01; t.o.irwrite = 1; t.o.pcen = 1; q.push_back(t);
    t = mk(1); t.o.asb = 2'b11;
    legal = (o inside {LW, SW, RT, BEQ, ADDI, JMP}) || (ext && (o inside {ANDI, ORI, SLTI}));
    if (!legal) begin t.o.illegal = 1; q.push_back(t); return; end
    q.push_back(t);
    if (o == LW || o == SW) begin
      t = mk(2); t.o.asa = 1; t.o.asb = 2'b10; q.push_back(t);
      if (o == LW) begin
        t = mk(3); t.o.iord = 1; q.push_back(t);
        t = mk(4); t.o.memtoreg = 1; t.o.regwrite = 1; q.push_back(t);
      end else begin
        t = mk(5); t.o.iord = 1; t.o.memwrite = 1; q.push_back(t);
      end
    end else if (o == RT) begin
      t = mk(6); t.o.asa = 1;
      case (f)
        6'b100000: t.o.alu = 3'b010;
        6'b100010: t.o.alu = 3'b110;
        6'b100100: t.o.alu = 3'b000;
        6'b100101: t.o.alu = 3'b001;
        6'b101010: t.o.alu = 3'b111;
        default:   t.o.illegal = 1;
      endcase
      q.push_back(t);
      if (!t.o.illegal) begin
        t = mk(7); t.o.regdst = 1; t.o.regwrite = 1; q.push_back(t);
      end
    end else if (o == BEQ) begin
      t = mk(8); t.o.asa = 1; t.o.alu = 3'b110; t.o.pcsrc = 2'b01; t.br = 1; q.push_back(t);
    end else if (o == JMP) begin
      t = mk(11); t.o.pcsrc = 2'b10; t.o.pcen = 1; q.push_back(t);
    end else begin
      t = mk(9); t.o.asa = 1; t.o.asb = 2'b10;
      t.o.alu = (o == ANDI) ? 3'b000 : (o == ORI) ? 3'b001 : (o == SLTI) ? 3'b111 : 3'b010;
      t.o.immzext = (o == ANDI) || (o == ORI);
      q.push_back(t);
      t = mk(10); t.o.regwrite = 1; q.push_back(t);
    end
  endtask

  task automatic check(input string tag, input obs_t exp, input bit sel0);
    obs_t got;
    got = sel0 ? obs0 : obs1;
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one instruction; zmode<0 randomizes zero per cycle. rst_at asserts
  // reset (of the EXT_IMM=1 DUT) in that step and aborts the instruction.
  task automatic run(input string tag, input bit sel0, input logic [5:0] o, input logic [5:0] f,
                     input int zmode, input int rst_at);
    build(o, f, !sel0);
    op = o; funct = f;
    foreach (q[k]) begin
      step_t t;
      t = q[k];
      zero = (zmode < 0) ? 1'($urandom) : zmode[0];
      if (k == rst_at) begin
        reset = 1;
        t.o.irwrite = 0; t.o.memwrite = 0; t.o.regwrite = 0; t.o.pcen = 0; t.o.illegal = 0;
      end else if (t.br && zero) begin
        t.o.pcen = 1;
      end
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), t.o, sel0);
      @(posedge clk); #1;
      if (k == rst_at) begin reset = 0; break; end
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [12];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP, ANDI, ORI, SLTI, RT, 6'd0, 6'd0};
    ops[10] = 6'($urandom);
    ops[11] = 6'($urandom);
    return ops[$urandom_range(0, 11)];
  endfunction

  function automatic logic [5:0] rand_fn();
    logic [5:0] fns [5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 3) == 0) return 6'($urandom);
    return fns[$urandom_range(0, 4)];
  endfunction

  initial begin
    step_t r;
    reset = 1; rst0 = 1; zero = 0; op = LW; funct = 6'b100000;
    @(posedge clk); #1;

    // Reset: FETCH with strobes suppressed
    r = mk(0); r.o.asb = 2'b01;
    for (int i = 0; i < 2; i++) begin
      zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("reset[%0d]", i), r.o, 1'b0);
      @(posedge clk); #1;
    end
    reset = 0;

    run("lw",      0, LW,  6'($urandom), -1, -1);
    run("sub",     0, RT,  6'b100010,    -1, -1);
    run("beq_z1",  0, BEQ, 6'd0,          1, -1);
    run("beq_z0",  0, BEQ, 6'd0,          0, -1);
    run("ori",     0, ORI, 6'd0,         -1, -1);
    run("andi",    0, ANDI, 6'd0,        -1, -1);
    run("slti",    0, SLTI, 6'd0,        -1, -1);
    run("badfn",   0, RT,  6'b000111,    -1, -1);
    run("sw_rst",  0, SW,  6'd0,         -1,  3);
    run("j",       0, JMP, 6'd0,         -1, -1);
    run("badop",   0, 6'b111111, 6'd0,   -1, -1);

    for (int i = 0; i < 150; i++) run($sformatf("rnd%0d", i), 0, rand_op(), rand_fn(), -1, -1);

    // Second DUT: immediate extension disabled
    reset = 1; rst0 = 0;
    run("ni_ori",  1, ORI,  6'd0,      -1, -1);
    run("ni_andi", 1, ANDI, 6'd0,      -1, -1);
    run("ni_slti", 1, SLTI, 6'd0,      -1, -1);
    run("ni_addi", 1, ADDI, 6'd0,      -1, -1);
    run("ni_lw",   1, LW,   6'd0,      -1, -1);
    run("ni_or",   1, RT,   6'b100101, -1, -1);
    for (int i = 0; i < 40; i++) run($sformatf("ni_rnd%0d", i), 1, rand_op(), rand_fn(), -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
